lfsr_value_source: RTL and testbench
====================================

// Module: lfsr_value_source
// PURPOSE
//  Pseudo-random 10-bit value producer: the upstream source that feeds the registered
//  A>B comparator's inputA, which turns values into game hazard/spawn decisions.
//  Steps a maximal-length XNOR Fibonacci LFSR once every TICK_DIV enabled cycles.
//  Presents each new value with a one-cycle valid strobe.
//  Supports seed loading, lock-up protection and full-period detection.
// PARAMETERS
//  WIDTH     10      value width; taps fixed for 10 (x^10 + x^7 + 1)
//  SEED      10'h001 reset/default seed; must not be all-ones
//  TICK_DIV  4       enabled cycles between LFSR steps; legal range 1..1023
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high
//  enable       in   1      1 = run tick counter and step LFSR; 0 = hold
//  load         in   1      load seed_in this cycle (synchronous)
//  seed_in      in   WIDTH  seed value for load
//  value        out  WIDTH  current LFSR state (registered)
//  value_valid  out  1      1-cycle pulse in the cycle value takes a new stepped value
//  seed_reject  out  1      1-cycle pulse: load was all-ones, SEED used instead
//  period_done  out  1      1-cycle pulse on the step that completes 1023 steps since last seed
// BEHAVIOUR
//  Reset (async, immediate):
//   value=SEED, value_valid=0, seed_reject=0, period_done=0
//   tick_cnt=TICK_DIV-1, step_cnt=0, state=IDLE
//  States:
//   IDLE: enable=0; counters hold at reload values
//   RUN:  enable=1
//   IDLE->RUN on enable=1; RUN->IDLE on enable=0
//   Entering IDLE reloads tick_cnt=TICK_DIV-1; step_cnt is kept
//  Step rule: fb = ~(value[9] ^ value[6]); next = {value[8:0], fb}
//  RUN, no load:
//   tick_cnt!=0: decrement tick_cnt
//   tick_cnt==0: step LFSR, tick_cnt<=TICK_DIV-1, value_valid<=1 (registered, same edge as value)
//   TICK_DIV=1: step every enabled cycle, value_valid continuously 1
//  Step latency: first step lands TICK_DIV cycles after the first cycle enable is sampled high
//  step_cnt:
//   increments on each step
//   on the step where step_cnt==1022: period_done<=1, step_cnt<=0
//   value then equals the seed it started from
//  load (any state; priority over step and enable):
//   value<=seed_in, or SEED if seed_in==all-ones, with seed_reject<=1
//   tick_cnt<=TICK_DIV-1, step_cnt<=0, value_valid<=0 that cycle
//  Simultaneous load and tick expiry: load wins; no step, no valid
//  Lock-up: all-ones is unreachable by stepping and is never loaded; value never equals 10'h3FF
//  Reset mid-run: all state returns to reset values asynchronously; pending pulses are dropped
//  Pulses are never stretched: each output is high for at most 1 cycle per event
//   (except the TICK_DIV=1 case above)
// TESTING
//  1. Reset, enable=1, TICK_DIV=4 -> value_valid every 4th cycle;
//     values 0x003,0x007,0x00F,0x01F,0x03F,0x07F,0x0FE
//  2. enable low for 10 cycles mid-run -> value frozen, no valid;
//     re-enable -> next step after exactly 4 cycles
//  3. load=1, seed_in=0x3FF -> value=0x001, seed_reject 1 cycle;
//     load seed_in=0x155 -> value=0x155, no reject
//  4. Run 1023 steps from 0x001 -> period_done pulses once, value back at 0x001;
//     no 0x3FF and no repeats seen
//  5. load asserted on the tick-expiry cycle -> value=seed_in, value_valid=0,
//     next valid 4 cycles later
//  6. Assert reset between edges mid-run -> outputs return to reset values before the next edge

Source files
------------

// File: rtl/lfsr_value_source.sv
// 10-bit XNOR Fibonacci LFSR value source with a tick divider, seed loading,
// all-ones seed rejection and full-period detection.
module lfsr_value_source #(
    parameter int                WIDTH    = 10,
    parameter logic [WIDTH-1:0]  SEED     = WIDTH'(1),
    parameter int                TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             seed_reject,
    output logic             period_done
);

    localparam logic [9:0]       TICK_RELOAD = 10'(TICK_DIV - 1);
    localparam logic [9:0]       LAST_STEP   = 10'd1022;
    localparam logic [WIDTH-1:0] ALL_ONES    = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       tick_q, tick_d;
    logic [9:0]       step_q, step_d;
    logic [WIDTH-1:0] value_d;
    logic             valid_d, reject_d, period_d;
    logic [WIDTH-1:0] stepped;

    // Taps x^10 + x^7: XNOR feedback makes all-ones the lock-up state, not zero.
    assign stepped = {value[WIDTH-2:0], ~(value[WIDTH-1] ^ value[WIDTH-4])};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= TICK_RELOAD;
            step_q      <= '0;
            value       <= SEED;
            value_valid <= 1'b0;
            seed_reject <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            step_q      <= step_d;
            value       <= value_d;
            value_valid <= valid_d;
            seed_reject <= reject_d;
            period_done <= period_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        step_d   = step_q;
        value_d  = value;
        valid_d  = 1'b0;
        reject_d = 1'b0;
        period_d = 1'b0;

        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counting keys off the live enable so the first step lands TICK_DIV
        // cycles after enable is first sampled high, not one cycle later.
        if (load) begin
            tick_d = TICK_RELOAD;
            step_d = '0;
            if (seed_in == ALL_ONES) begin
                value_d  = SEED;
                reject_d = 1'b1;
            end else begin
                value_d = seed_in;
            end
        end else if (enable) begin
            if (tick_q == 10'd0) begin
                tick_d  = TICK_RELOAD;
                value_d = stepped;
                valid_d = 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d   = '0;
                    period_d = 1'b1;
                end else begin
                    step_d = step_q + 10'd1;
                end
            end else begin
                tick_d = tick_q - 10'd1;
            end
        end else if (state_q == RUN) begin
            tick_d = TICK_RELOAD;
        end
    end

endmodule

// File: tb/tb_lfsr_value_source.sv
// Scoreboard bench for lfsr_value_source: a driver predicts pulse events from a
// behavioural model, a monitor pops and compares them as the DUT pulses.
module tb_lfsr_value_source;

    localparam int         TICK_DIV = 4;
    localparam logic [9:0] SEED     = 10'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [9:0] seed_in;
    logic [9:0] value;
    logic       value_valid;
    logic       seed_reject;
    logic       period_done;

    typedef struct {
        int         tag;
        logic [9:0] value;
        bit         valid;
        bit         reject;
        bit         period;
    } ev_t;

    ev_t sb[$];

    int checks     = 0;
    int errors     = 0;
    int edge_count = 0;

    logic [9:0] m_value;
    int         m_since;
    int         m_steps;

    lfsr_value_source #(
        .WIDTH   (10),
        .SEED    (SEED),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .seed_in    (seed_in),
        .value      (value),
        .value_valid(value_valid),
        .seed_reject(seed_reject),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, actual, expected, edge_count);
        end
    endtask

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], ~(v[9] ^ v[6])};
    endfunction

    // Model: a step happens on every TICK_DIV-th consecutive enabled cycle;
    // a full period is 1023 steps since the last seed.
    task automatic apply_stimulus(input bit en, input bit ld, input logic [9:0] seed);
        ev_t e;
        @(negedge clk);
        enable  = en;
        load    = ld;
        seed_in = seed;
        e.tag    = edge_count + 1;
        e.valid  = 1'b0;
        e.reject = 1'b0;
        e.period = 1'b0;
        if (ld) begin
            m_since = 0;
            m_steps = 0;
            if (seed == 10'h3FF) begin
                m_value  = SEED;
                e.reject = 1'b1;
                e.value  = m_value;
                sb.push_back(e);
            end else begin
                m_value = seed;
            end
        end else if (en) begin
            m_since++;
            if (m_since == TICK_DIV) begin
                m_since = 0;
                m_value = lfsr_next(m_value);
                m_steps++;
                if (m_steps == 1023) begin
                    e.period = 1'b1;
                    m_steps  = 0;
                end
                e.valid = 1'b1;
                e.value = m_value;
                sb.push_back(e);
            end
        end else begin
            m_since = 0;
        end
    endtask

    task automatic model_reset();
        m_value = SEED;
        m_since = 0;
        m_steps = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].tag < edge_count) begin
                check_output("missed_event_tag", 0, sb[0].tag);
                void'(sb.pop_front());
            end
            if (value_valid || seed_reject || period_done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_pulse", {value_valid, seed_reject, period_done}, 0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    check_output("event_edge", edge_count, e.tag);
                    check_output("event_value", value, e.value);
                    check_output("event_valid", value_valid, e.valid);
                    check_output("event_reject", seed_reject, e.reject);
                    check_output("event_period", period_done, e.period);
                end
            end
            if (value == 10'h3FF) check_output("lockup_value", value, 0);
        end
    end

    initial begin
        logic [9:0] s;
        reset   = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        seed_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_value", value, SEED);
        check_output("reset_valid", value_valid, 0);
        check_output("reset_reject", seed_reject, 0);
        check_output("reset_period", period_done, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] free run from reset seed");
        repeat (7 * TICK_DIV) apply_stimulus(1, 0, '0);

        $display("[TB] enable pause and resume");
        repeat (2) apply_stimulus(1, 0, '0);
        repeat (10) apply_stimulus(0, 0, '0);
        repeat (9) apply_stimulus(1, 0, '0);

        $display("[TB] seed loading");
        apply_stimulus(0, 1, 10'h3FF);
        apply_stimulus(0, 0, '0);
        apply_stimulus(0, 1, 10'h155);
        @(negedge clk);
        check_output("load_value", value, 10'h155);
        repeat (2 * TICK_DIV) apply_stimulus(1, 0, '0);

        $display("[TB] full period from 0x001");
        apply_stimulus(0, 1, 10'h001);
        repeat (1023 * TICK_DIV) apply_stimulus(1, 0, '0);
        apply_stimulus(0, 0, '0);
        check_output("period_return_value", value, 10'h001);

        $display("[TB] load on tick expiry");
        apply_stimulus(1, 0, '0);
        while (m_since != TICK_DIV - 1) apply_stimulus(1, 0, '0);
        apply_stimulus(1, 1, 10'h2A5);
        repeat (2 * TICK_DIV + 1) apply_stimulus(1, 0, '0);

        $display("[TB] asynchronous reset mid-run");
        while (m_since != TICK_DIV - 1) apply_stimulus(1, 0, '0);
        apply_stimulus(1, 0, '0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_output("midrun_reset_value", value, SEED);
        check_output("midrun_reset_valid", value_valid, 0);
        check_output("midrun_reset_period", period_done, 0);
        enable = 1'b0;
        load   = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        repeat (3 * TICK_DIV) apply_stimulus(1, 0, '0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
            apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, s);
        end

        repeat (2) apply_stimulus(0, 0, '0);
        @(negedge clk);
        check_output("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
